// File: rtl/cpu.sv
// Multicycle RV32I core (FETCH/EXEC/WB) with on-chip imem/dmem and a polled UART.
// Optional MMIO cycle/retired-instruction counters are built when CPU_COUNTERS_EN is defined.

module cpu_mem (
    input  logic        clk,
    input  logic [13:0] raddr,
    output logic [31:0] rdata,
    input  logic [13:0] waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we
);
    logic [31:0] mem [0:16383];

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

module uart_transmitter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] clk_cnt;
    logic          busy;

    // Idle shifts ones in, so the line sits high between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            shreg   <= '1;
            bit_cnt <= '0;
            clk_cnt <= '0;
        end else if (!busy) begin
            if (data_in_valid) begin
                busy    <= 1'b1;
                shreg   <= {1'b1, data_in, 1'b0};
                bit_cnt <= '0;
                clk_cnt <= '0;
            end
        end else if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            shreg   <= {1'b1, shreg[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) busy <= 1'b0;
        end else begin
            clk_cnt <= clk_cnt + CW'(1);
        end
    end

    assign serial_out    = shreg[0];
    assign data_in_ready = !busy;
endmodule

module uart_receiver #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    input  logic       data_out_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    logic [1:0]    sync;
    logic [7:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] clk_cnt;
    logic          busy;
    logic          rx;

    assign rx = sync[1];

    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], serial_in};
    end

    // A completed frame is written after the pop, so a new byte wins over a same-cycle pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy           <= 1'b0;
            data_out_valid <= 1'b0;
            bit_cnt        <= '0;
            clk_cnt        <= '0;
        end else begin
            if (data_out_ready) data_out_valid <= 1'b0;
            if (!busy) begin
                if (!rx) begin
                    busy    <= 1'b1;
                    bit_cnt <= '0;
                    clk_cnt <= HALF;
                end
            end else if (clk_cnt != '0) begin
                clk_cnt <= clk_cnt - CW'(1);
            end else begin
                clk_cnt <= LAST;
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd0) begin
                    if (rx) busy <= 1'b0;
                end else if (bit_cnt == 4'd9) begin
                    busy <= 1'b0;
                    if (rx) begin
                        data_out       <= shreg;
                        data_out_valid <= 1'b1;
                    end
                end else begin
                    shreg <= {rx, shreg[7:1]};
                end
            end
        end
    end
endmodule

module cpu #(
    parameter int          CPU_CLOCK_FREQ = 50_000_000,
    parameter logic [31:0] RESET_PC       = 32'h1000_0000,
    parameter int          BAUD_RATE      = 115_200
) (
    input  logic clk,
    input  logic rst,
    input  logic bp_enable,
    input  logic serial_in,
    output logic serial_out
);
    localparam int CLKS_PER_BIT = CPU_CLOCK_FREQ / BAUD_RATE;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
        OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
        OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011, OP_SYSTEM = 7'b1110011;
    localparam logic [29:0] MMIO_STATUS = 30'h2000_0000, MMIO_RX = 30'h2000_0001,
        MMIO_TX = 30'h2000_0002, MMIO_CYCLE = 30'h2000_0004, MMIO_INSTRET = 30'h2000_0005,
        MMIO_CLEAR = 30'h2000_0006;

    typedef enum logic [1:0] {FETCH, EXEC, WB} state_t;
    state_t state, state_next;

    logic [31:0] pc, pc_next, inst, rs1_v, rs2_v, addr, alu_b, alu_y, rd_data, load_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, st_data, dmem_rdata, mmio_rdata, ld_mmio;
    logic [31:0] ld_word, ld_shift, tohost, cycle_rd, instret_rd;
    logic [31:0] regs [0:31];
    logic [29:0] word_addr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [3:0]  st_be, dmem_we, imem_we;
    logic [7:0]  rx_data;
    logic        rd_we, taken, alu_alt, store_en, ld_dmem, rx_valid, rx_pop, tx_ready, tx_start;
    logic        unused_bits;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'd0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign rs1_v     = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_v     = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign addr      = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign word_addr = addr[31:2];
    assign alu_b     = (opcode == OP_OP) ? rs2_v : imm_i;
    assign alu_alt   = inst[30] & ((opcode == OP_OP) | (funct3 == 3'b101));

    always_comb begin
        case (funct3)
            3'b000:  alu_y = alu_alt ? rs1_v - alu_b : rs1_v + alu_b;
            3'b001:  alu_y = rs1_v << alu_b[4:0];
            3'b010:  alu_y = {31'd0, $signed(rs1_v) < $signed(alu_b)};
            3'b011:  alu_y = {31'd0, rs1_v < alu_b};
            3'b100:  alu_y = rs1_v ^ alu_b;
            3'b101:  alu_y = alu_alt ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
            3'b110:  alu_y = rs1_v | alu_b;
            default: alu_y = rs1_v & alu_b;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = rs1_v == rs2_v;
            3'b001:  taken = rs1_v != rs2_v;
            3'b100:  taken = $signed(rs1_v) < $signed(rs2_v);
            3'b101:  taken = $signed(rs1_v) >= $signed(rs2_v);
            3'b110:  taken = rs1_v < rs2_v;
            3'b111:  taken = rs1_v >= rs2_v;
            default: taken = 1'b0;
        endcase
    end

    // In WB the imem output still holds the load (read with the pre-increment PC).
    assign ld_word  = ld_dmem ? dmem_rdata : ld_mmio;
    assign ld_shift = ld_word >> {addr[1:0], 3'b000};
    always_comb begin
        case (funct3)
            3'b000:  load_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  load_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  load_val = {24'd0, ld_shift[7:0]};
            3'b101:  load_val = {16'd0, ld_shift[15:0]};
            default: load_val = ld_word;
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   begin st_data = {4{rs2_v[7:0]}};  st_be = 4'b0001 << addr[1:0]; end
            2'b01:   begin st_data = {2{rs2_v[15:0]}}; st_be = addr[1] ? 4'b1100 : 4'b0011; end
            default: begin st_data = rs2_v;            st_be = 4'b1111; end
        endcase
    end

    assign store_en = (state == EXEC) && (opcode == OP_STORE) && !rst;
    assign dmem_we  = (store_en && addr[31:28] == 4'b0001) ? st_be : 4'd0;
    assign imem_we  = (store_en && addr[31:28] == 4'b0010) ? st_be : 4'd0;
    assign tx_start = store_en && (word_addr == MMIO_TX) && tx_ready;
    assign rx_pop   = (state == EXEC) && (opcode == OP_LOAD) && (word_addr == MMIO_RX);

    always_comb begin
        case (word_addr)
            MMIO_STATUS:  mmio_rdata = {30'd0, rx_valid, tx_ready};
            MMIO_RX:      mmio_rdata = {24'd0, rx_data};
            MMIO_CYCLE:   mmio_rdata = cycle_rd;
            MMIO_INSTRET: mmio_rdata = instret_rd;
            default:      mmio_rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        rd_we      = 1'b0;
        rd_data    = alu_y;
        case (state)
            FETCH: state_next = EXEC;
            EXEC: begin
                state_next = (opcode == OP_LOAD) ? WB : FETCH;
                pc_next    = pc + 32'd4;
                case (opcode)
                    OP_LUI:        begin rd_we = 1'b1; rd_data = imm_u; end
                    OP_AUIPC:      begin rd_we = 1'b1; rd_data = pc + imm_u; end
                    OP_JAL:        begin rd_we = 1'b1; rd_data = pc + 32'd4; pc_next = pc + imm_j; end
                    OP_JALR:       begin rd_we = 1'b1; rd_data = pc + 32'd4; pc_next = addr & ~32'd1; end
                    OP_BRANCH:     if (taken) pc_next = pc + imm_b;
                    OP_IMM, OP_OP: rd_we = 1'b1;
                    default:       ;
                endcase
            end
            WB: begin
                state_next = FETCH;
                rd_we      = 1'b1;
                rd_data    = load_val;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            tohost <= 32'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == EXEC && opcode == OP_SYSTEM && inst[31:20] == 12'h51E && funct3[1:0] == 2'b01)
                tohost <= funct3[2] ? {27'd0, rs1} : rs1_v;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rd_we && rd != 5'd0) regs[rd] <= rd_data;
        if (state == EXEC) begin
            ld_dmem <= (addr[31:28] == 4'b0001);
            ld_mmio <= mmio_rdata;
        end
    end

`ifdef CPU_COUNTERS_EN
    logic [31:0] cycle_cnt, instret_cnt;
    always_ff @(posedge clk) begin
        if (rst || (store_en && word_addr == MMIO_CLEAR)) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state == WB || (state == EXEC && opcode != OP_LOAD))
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
    assign cycle_rd   = cycle_cnt;
    assign instret_rd = instret_cnt;
`else
    assign cycle_rd   = 32'd0;
    assign instret_rd = 32'd0;
`endif

    // tohost is write-only from the core's side; bp_enable is reserved.
    assign unused_bits = ^{tohost, bp_enable};

    cpu_mem imem (.clk(clk), .raddr(pc[15:2]), .rdata(inst), .waddr(addr[15:2]),
                  .wdata(st_data), .we(imem_we));
    cpu_mem dmem (.clk(clk), .raddr(addr[15:2]), .rdata(dmem_rdata), .waddr(addr[15:2]),
                  .wdata(st_data), .we(dmem_we));

    uart_transmitter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk(clk), .rst(rst), .data_in(rs2_v[7:0]), .data_in_valid(tx_start),
        .data_in_ready(tx_ready), .serial_out(serial_out));

    uart_receiver #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk(clk), .rst(rst), .serial_in(serial_in), .data_out_ready(rx_pop),
        .data_out(rx_data), .data_out_valid(rx_valid));
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: arithmetic/jump program, sub-word load/store program,
// MMIO TX frame, reset during a frame, and a 10-byte UART echo program.

module tb_cpu;
    localparam int          BIT      = 50;
    localparam logic [31:0] RESET_PC = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bp_enable = 1'b0;
    logic serial_in = 1'b1;
    logic serial_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] prog_q[$];

    cpu #(.CPU_CLOCK_FREQ(50_000_000), .RESET_PC(RESET_PC), .BAUD_RATE(1_000_000)) dut (
        .clk(clk), .rst(rst), .bp_enable(bp_enable), .serial_in(serial_in), .serial_out(serial_out));

    // clock / reset
    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic start_prog();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        foreach (prog_q[i]) dut.imem.mem[14'(i)] = prog_q[i];
        rst = 1'b0;
    endtask

    task automatic uart_send(input logic [7:0] b);
        serial_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (BIT) @(negedge clk);
        end
        serial_in = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    // scoreboard: decode one frame from serial_out against exp_q
    task automatic uart_recv(input string tag);
        int waited = 0;
        logic [7:0] got;
        logic [7:0] exp;
        while (serial_out !== 1'b0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        repeat (BIT / 2) @(negedge clk);
        check({tag, " start"}, {31'd0, serial_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            got[i] = serial_out;
        end
        repeat (BIT) @(negedge clk);
        check({tag, " stop"}, {31'd0, serial_out}, 32'd1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        check({tag, " data"}, {24'd0, got}, {24'd0, exp});
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("reset serial_out", {31'd0, serial_out}, 32'd1);
        check("reset pc", dut.pc, RESET_PC);
        check("reset state", 32'(dut.state), 32'd0);

        // arithmetic, x0, auipc/jalr
        prog_q = '{32'h00500093, 32'hFF908113, 32'h40208233, 32'h100002B7, 32'h0022A023,
                   32'h00100013, 32'h0002A223, 32'h00000397, 32'h00D38467, 32'h00100493,
                   32'h00300493, 32'h0000006F};
        dut.dmem.mem[0] = 32'h0;
        dut.dmem.mem[1] = 32'hDEAD_BEEF;
        start_prog();
        repeat (60) @(negedge clk);
        check("sw addi result", dut.dmem.mem[0], 32'hFFFF_FFFE);
        check("x0 stored", dut.dmem.mem[1], 32'h0);
        check("x1", dut.regs[1], 32'd5);
        check("x2", dut.regs[2], 32'hFFFF_FFFE);
        check("sub x4", dut.regs[4], 32'd7);
        check("auipc x7", dut.regs[7], 32'h1000_001C);
        check("jalr link x8", dut.regs[8], 32'h1000_0024);
        check("jalr skip x9", dut.regs[9], 32'd3);

        // sub-word loads and stores
        prog_q = '{32'h100002B7, 32'h80818337, 32'h28330313, 32'h0062A023, 32'h00028503,
                   32'h00128583, 32'h0022C603, 32'h0032C683, 32'h00029703, 32'h0022D783,
                   32'h00229803, 32'h0002D883, 32'h0002A903, 32'h006282A3, 32'h00629523,
                   32'h0000006F};
        dut.dmem.mem[1] = 32'h0;
        dut.dmem.mem[2] = 32'h0;
        start_prog();
        repeat (100) @(negedge clk);
        check("lb +0", dut.regs[10], 32'hFFFF_FF83);
        check("lb +1", dut.regs[11], 32'hFFFF_FF82);
        check("lbu +2", dut.regs[12], 32'h0000_0081);
        check("lbu +3", dut.regs[13], 32'h0000_0080);
        check("lh +0", dut.regs[14], 32'hFFFF_8283);
        check("lhu +2", dut.regs[15], 32'h0000_8081);
        check("lh +2", dut.regs[16], 32'hFFFF_8081);
        check("lhu +0", dut.regs[17], 32'h0000_8283);
        check("lw", dut.regs[18], 32'h8081_8283);
        check("sb +5", dut.dmem.mem[1], 32'h0000_8300);
        check("sh +10", dut.dmem.mem[2], 32'h8283_0000);

        // MMIO TX of 0x41, status read right after, counter read
        prog_q = '{32'h800000B7, 32'h04100113, 32'h0020A423, 32'h0000A183, 32'h0100A203,
                   32'h0000006F};
        dut.regs[3] = 32'hFFFF_FFFF;
        dut.regs[4] = 32'hFFFF_FFFF;
        exp_q.push_back(8'h41);
        start_prog();
        uart_recv("tx 0x41");
        check("status while busy", dut.regs[3], 32'd0);
`ifndef CPU_COUNTERS_EN
        check("cycle counter absent", dut.regs[4], 32'd0);
`endif

        // reset during a TX frame
        start_prog();
        for (int w = 0; w < 200 && serial_out !== 1'b0; w++) @(negedge clk);
        check("abort frame started", {31'd0, serial_out}, 32'd0);
        repeat (120) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort serial_out", {31'd0, serial_out}, 32'd1);
        check("abort pc", dut.pc, RESET_PC);
        check("abort state", 32'(dut.state), 32'd0);
`ifdef CPU_COUNTERS_EN
        check("abort cycle counter", dut.cycle_cnt, 32'd0);
`endif

        // echo program
        prog_q = '{32'h800000B7, 32'h0000A103, 32'h00217113, 32'hFE010CE3, 32'h0040A183,
                   32'h0000A103, 32'h00117113, 32'hFE010CE3, 32'h0030A423, 32'hFE1FF06F};
        start_prog();
        for (int k = 0; k < 10; k++) exp_q.push_back(8'h61 + 8'(k));
        fork
            for (int j = 0; j < 10; j++) begin
                uart_send(8'h61 + 8'(j));
                repeat (100) @(negedge clk);
            end
        join_none
        for (int k = 0; k < 10; k++) uart_recv("echo");
        wait fork;
        check("echo queue drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
